// File: rtl/mux_exerciser.sv
// mux_exerciser: on-chip stimulus generator and response checker for a 4:1 mux
// with two output implementations (bfg and gf). It sweeps all 64 combinations
// of {s1,s0,i3..i0} and then reports a saturating mismatch count per output,
// along with pass/done.
//
// Optional build macro MUX_EXERCISER_CAPTURE_EN adds a first-failure capture
// (fail_valid_o, fail_vec_o, fail_obs_o).
//
// Handshake: start_i and abort_i are single-cycle pulses sampled on wb_clk_i.
// start_i is accepted only in IDLE. abort_i has priority over start_i, and
// abort_i takes effect in any non-IDLE state.
module mux_exerciser #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 7
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             bfg_out_i,
    input  logic             gf_out_i,
    output logic [3:0]       drv_i_o,
    output logic [1:0]       drv_s_o,
    output logic [5:0]       vec_idx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] bfg_err_o,
    output logic [ERR_W-1:0] gf_err_o
`ifdef MUX_EXERCISER_CAPTURE_EN
    ,
    output logic             fail_valid_o,
    output logic [5:0]       fail_vec_o,
    output logic [1:0]       fail_obs_o
`endif
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] settle_cnt_q;
    logic [1:0]       bfg_sync_q;
    logic [1:0]       gf_sync_q;
    logic             start_go;
    logic             abort_go;
    logic             exp_bit;
    logic             bfg_mis;
    logic             gf_mis;

    // Two-flop synchronizers on the returning mux outputs.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            bfg_sync_q <= 2'b00;
            gf_sync_q  <= 2'b00;
        end else begin
            bfg_sync_q <= {bfg_sync_q[0], bfg_out_i};
            gf_sync_q  <= {gf_sync_q[0], gf_out_i};
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and decoded strobes.
    // exp_bit selects data bit v[5:4] out of v[3:0].
    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        abort_go = 1'b0;
        exp_bit  = vec_idx_o[vec_idx_o[5:4]];
        bfg_mis  = (bfg_sync_q[1] != exp_bit);
        gf_mis   = (gf_sync_q[1] != exp_bit);
        if (state_q == S_IDLE) begin
            if (start_i && !abort_i) begin
                start_go = 1'b1;
                state_d  = S_DRIVE;
            end
        end else if (abort_i) begin
            abort_go = 1'b1;
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_DRIVE:  state_d = S_SETTLE;
                S_SETTLE: if (settle_cnt_q == '0) state_d = S_SAMPLE;
                S_SAMPLE: state_d = (vec_idx_o == 6'd63) ? S_DONE : S_DRIVE;
                S_DONE:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: drive registers, settle counter, error counters and status flags.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            drv_i_o      <= 4'd0;
            drv_s_o      <= 2'd0;
            vec_idx_o    <= 6'd0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            pass_o       <= 1'b0;
            bfg_err_o    <= '0;
            gf_err_o     <= '0;
            settle_cnt_q <= '0;
        end else if (start_go) begin
            bfg_err_o <= '0;
            gf_err_o  <= '0;
            done_o    <= 1'b0;
            pass_o    <= 1'b0;
            vec_idx_o <= 6'd0;
            busy_o    <= 1'b1;
        end else if (abort_go) begin
            busy_o  <= 1'b0;
            drv_i_o <= 4'd0;
            drv_s_o <= 2'd0;
        end else begin
            case (state_q)
                S_DRIVE: begin
                    drv_i_o      <= vec_idx_o[3:0];
                    drv_s_o      <= vec_idx_o[5:4];
                    settle_cnt_q <= CNT_W'(SETTLE_CYCLES - 1);
                end
                S_SETTLE: begin
                    if (settle_cnt_q != '0) settle_cnt_q <= settle_cnt_q - 1'b1;
                end
                S_SAMPLE: begin
                    if (bfg_mis && bfg_err_o != ERR_MAX) bfg_err_o <= bfg_err_o + 1'b1;
                    if (gf_mis && gf_err_o != ERR_MAX) gf_err_o <= gf_err_o + 1'b1;
                    if (vec_idx_o != 6'd63) vec_idx_o <= vec_idx_o + 1'b1;
                end
                S_DONE: begin
                    done_o  <= 1'b1;
                    pass_o  <= (bfg_err_o == '0) && (gf_err_o == '0);
                    busy_o  <= 1'b0;
                    drv_i_o <= 4'd0;
                    drv_s_o <= 2'd0;
                end
                default: ;
            endcase
        end
    end

`ifdef MUX_EXERCISER_CAPTURE_EN
    // First-failure capture; later failures never overwrite it.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || start_go) begin
            fail_valid_o <= 1'b0;
            fail_vec_o   <= 6'd0;
            fail_obs_o   <= 2'b00;
        end else if (state_q == S_SAMPLE && !abort_i && (bfg_mis || gf_mis) && !fail_valid_o) begin
            fail_valid_o <= 1'b1;
            fail_vec_o   <= vec_idx_o;
            fail_obs_o   <= {bfg_sync_q[1], gf_sync_q[1]};
        end
    end
`endif

endmodule
